axi4_stream_to_axi4: RTL and testbench
======================================

Name: axi4_stream_to_axi4

Overview:
Frame-buffer write stage, sitting directly upstream of the memory-to-stream reader. It accepts one AXI4-Stream packet per start strobe and stages it in an internal burst buffer. It writes the packet to memory as AXI4 INCR write bursts, starting at a base address. On completion it reports the packet byte size, which the reader consumes as its packet size.

Parameters:
DATA_WIDTH, 64, data bus width in bits (DATA_WIDTH_B = DATA_WIDTH/8)
ADDR_WIDTH, 32, AXI address width
ID_WIDTH, 1, AXI ID width, driven 0
AWUSER_WIDTH, 1, awuser width, driven 0
WUSER_WIDTH, 1, wuser width, driven 0
ARUSER_WIDTH, 1, aruser width, driven 0
MAX_BURST_LEN, 256, burst buffer depth in words, range 1..256
MAX_PKT_SIZE_B, 2048, maximum stored packet size in bytes (multiple of DATA_WIDTH_B)
MAX_PKT_SIZE_WIDTH, $clog2(MAX_PKT_SIZE_B), size field width

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
addr_i  in  ADDR_WIDTH  packet base address, sampled with wr_stb_i
wr_stb_i  in  1  start strobe, honoured only in IDLE_S
pkt_i  axi4_stream_if.slave  -  input packet (tdata, tkeep, tvalid, tready, tlast)
mem_o  axi4_if.master  -  memory port, write channels used
pkt_size_o  out  MAX_PKT_SIZE_WIDTH+1  stored bytes of the last packet, valid with done_o
done_o  out  1  one-cycle pulse when the packet is fully written (final bresp received)
trunc_o  out  1  valid with done_o; packet exceeded MAX_PKT_SIZE_B
wr_err_o  out  1  valid with done_o; at least one bresp != OKAY

Behaviour:
- Reset: state IDLE_S; awvalid, wvalid, tready, done_o, trunc_o, wr_err_o = 0; pkt_size_o, awaddr, awlen and counters = 0.
- Fixed fields: awsize = log2(DATA_WIDTH_B), awburst = INCR, other aw* = 0. Read channel inactive: arvalid = 0, rready = 1.
- IDLE_S: on wr_stb_i, load cur_addr = addr_i with the low log2(DATA_WIDTH_B) bits cleared. Clear byte count, truncation flag and error flag. Go to FILL_S.
- FILL_S entry: compute burst_lim = min(MAX_BURST_LEN, remaining words before the next 4 KB boundary of cur_addr, remaining words to MAX_PKT_SIZE_B); buf_cnt = 0.
- FILL_S: tready = 1.
  - Each handshake stores tdata and tkeep at buf[buf_cnt], increments buf_cnt, and adds popcount(tkeep) to the byte count.
  - Go to ADDR_S on the handshake carrying tlast, or on the handshake making buf_cnt == burst_lim.
  - tready drops from the following cycle.
- ADDR_S: awvalid = 1, awaddr = cur_addr, awlen = buf_cnt-1; both are registered and held stable until awready. Go to DATA_S.
- DATA_S: wvalid = 1, wdata/wstrb = buf[rd_ptr] (data and stored tkeep), wlast = (rd_ptr == buf_cnt-1). rd_ptr advances on each handshake. After the wlast handshake, go to RESP_S.
- RESP_S: bready = 1. On bvalid:
  - bresp != 2'b00 sets the sticky error flag.
  - cur_addr += buf_cnt*DATA_WIDTH_B.
  - If tlast was seen: pulse done_o, go to IDLE_S.
  - Else if the byte count reached MAX_PKT_SIZE_B: set trunc, go to DROP_S.
  - Else go to FILL_S.
- DROP_S: tready = 1; words are discarded. On the tlast handshake, pulse done_o with trunc_o = 1 and go to IDLE_S.
- Only one burst is outstanding; the stream is back-pressured throughout ADDR_S, DATA_S and RESP_S.
- pkt_size_o updates at the done_o cycle and holds until the next done_o.
- wr_stb_i outside IDLE_S is ignored. tlast arriving with tkeep = 0 is still written, with wstrb = 0.
- Packet ending exactly on a burst or 4 KB limit: the tlast burst is final, and no empty burst is issued.
- Reset mid-operation aborts immediately to reset values; the system reset also resets the memory slave.

Test Plan:
- DATA_WIDTH=64, addr_i=0x1000, 40-byte packet (5 words, last tkeep=0xFF) -> one burst awaddr=0x1000 awlen=4, wlast on word 5, done_o with pkt_size_o=40.
- 2048-byte packet at 0x0 -> bursts awlen=255 at 0x0; pkt_size_o=2048, trunc_o=0.
- Packet of 37 bytes at 0x0FF0 -> burst at 0x0FF0 awlen=1, then 0x1000 awlen=2; last wstrb=0x1F; pkt_size_o=37.
- 2100-byte packet -> 2048 bytes written, excess tail accepted and dropped, done_o after tlast, trunc_o=1, pkt_size_o=2048.
- Slave returns bresp=SLVERR on burst 1 of 2 with random awready/wready/bvalid stalls -> both bursts complete, wr_err_o=1; wr_stb_i during the transfer is ignored.
- rst_i asserted during DATA_S -> awvalid/wvalid/tready 0 immediately; a new wr_stb_i after release starts cleanly at the new address.

Source files
------------

// File: rtl/axi4_stream_to_axi4_if.sv
// Bus bundles for the stream-to-memory write stage: an AXI4-Stream packet port
// and a full AXI4 memory port, each with master/slave modports.
interface axi4_stream_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tvalid;
  logic                    tready;
  logic                    tlast;

  modport master (output tdata, tkeep, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

interface axi4_if #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 64,
  parameter int ID_WIDTH     = 1,
  parameter int AWUSER_WIDTH = 1,
  parameter int WUSER_WIDTH  = 1,
  parameter int ARUSER_WIDTH = 1
);
  logic [ID_WIDTH-1:0]     awid;
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic [3:0]              awcache;
  logic [2:0]              awprot;
  logic [3:0]              awqos;
  logic [3:0]              awregion;
  logic [AWUSER_WIDTH-1:0] awuser;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic [WUSER_WIDTH-1:0]  wuser;
  logic                    wvalid;
  logic                    wready;
  logic [ID_WIDTH-1:0]     bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ID_WIDTH-1:0]     arid;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic [3:0]              arcache;
  logic [2:0]              arprot;
  logic [3:0]              arqos;
  logic [3:0]              arregion;
  logic [ARUSER_WIDTH-1:0] aruser;
  logic                    arvalid;
  logic                    arready;
  logic [ID_WIDTH-1:0]     rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion,
           awuser, awvalid, wdata, wstrb, wlast, wuser, wvalid, bready,
           arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion,
           aruser, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi4_stream_to_axi4.sv
// Frame-buffer write stage: stages one stream packet per start strobe in a burst
// buffer and writes it to memory as AXI4 INCR bursts, reporting the stored size.
module axi4_stream_to_axi4 #(
  parameter int DATA_WIDTH         = 64,
  parameter int ADDR_WIDTH         = 32,
  parameter int ID_WIDTH           = 1,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int MAX_BURST_LEN      = 256,
  parameter int MAX_PKT_SIZE_B     = 2048,
  parameter int MAX_PKT_SIZE_WIDTH = $clog2(MAX_PKT_SIZE_B)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [ADDR_WIDTH-1:0]         addr_i,
  input  logic                          wr_stb_i,
  axi4_stream_if.slave                  pkt_i,
  axi4_if.master                        mem_o,
  output logic [MAX_PKT_SIZE_WIDTH:0]   pkt_size_o,
  output logic                          done_o,
  output logic                          trunc_o,
  output logic                          wr_err_o
);
  localparam int DATA_WIDTH_B = DATA_WIDTH / 8;
  localparam int OFF_W        = $clog2(DATA_WIDTH_B);
  localparam int CNT_W        = $clog2(MAX_BURST_LEN + 1);
  localparam int IDX_W        = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1;
  localparam int SIZE_W       = MAX_PKT_SIZE_WIDTH + 1;

  typedef enum logic [2:0] {IDLE_S, FILL_S, ADDR_S, DATA_S, RESP_S, DROP_S} state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d, awaddr_q, awaddr_d;
  logic [SIZE_W-1:0]       byte_cnt_q, byte_cnt_d, pkt_size_q, pkt_size_d;
  logic [CNT_W-1:0]        buf_cnt_q, buf_cnt_d, burst_lim_q, burst_lim_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]              awlen_q, awlen_d;
  logic                    awvalid_q, awvalid_d, wvalid_q, wvalid_d;
  logic                    last_seen_q, last_seen_d, err_flag_q, err_flag_d;
  logic                    done_q, done_d, trunc_q, trunc_d, wr_err_q, wr_err_d;
  logic                    wlast;

  logic [DATA_WIDTH-1:0]   buf_data_q [MAX_BURST_LEN];
  logic [DATA_WIDTH_B-1:0] buf_keep_q [MAX_BURST_LEN];

  // Burst length allowed from address a with `bytes` already stored.
  function automatic logic [CNT_W-1:0] calc_lim(logic [ADDR_WIDTH-1:0] a, logic [SIZE_W-1:0] bytes);
    logic [12:0]       to_4k;
    logic [SIZE_W-1:0] to_max;
    logic [CNT_W-1:0]  lim;
    to_4k  = (13'h1000 - {1'b0, a[11:0]}) >> OFF_W;
    to_max = (SIZE_W'(MAX_PKT_SIZE_B) - bytes) >> OFF_W;
    lim    = CNT_W'(MAX_BURST_LEN);
    if (32'(to_4k) < 32'(lim))  lim = CNT_W'(to_4k);
    if (32'(to_max) < 32'(lim)) lim = CNT_W'(to_max);
    return lim;
  endfunction

  assign wlast = (rd_ptr_q == buf_cnt_q - CNT_W'(1));

  always_comb begin
    // NOTE: every next-state value gets a default first so no path infers a latch.
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    awaddr_d    = awaddr_q;
    byte_cnt_d  = byte_cnt_q;
    pkt_size_d  = pkt_size_q;
    buf_cnt_d   = buf_cnt_q;
    burst_lim_d = burst_lim_q;
    rd_ptr_d    = rd_ptr_q;
    awlen_d     = awlen_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    last_seen_d = last_seen_q;
    err_flag_d  = err_flag_q;
    done_d      = 1'b0;
    trunc_d     = trunc_q;
    wr_err_d    = wr_err_q;
    case (state_q)
      IDLE_S: if (wr_stb_i) begin
        cur_addr_d  = {addr_i[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
        byte_cnt_d  = '0;
        last_seen_d = 1'b0;
        err_flag_d  = 1'b0;
        state_d     = FILL_S;
      end
      FILL_S: if (pkt_i.tvalid) begin
        buf_cnt_d  = buf_cnt_q + CNT_W'(1);
        byte_cnt_d = byte_cnt_q + SIZE_W'($countones(pkt_i.tkeep));
        if (pkt_i.tlast) last_seen_d = 1'b1;
        if (pkt_i.tlast || buf_cnt_d == burst_lim_q) begin
          awvalid_d = 1'b1;
          awaddr_d  = cur_addr_q;
          awlen_d   = 8'(buf_cnt_q);
          state_d   = ADDR_S;
        end
      end
      ADDR_S: if (mem_o.awready) begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b1;
        rd_ptr_d  = '0;
        state_d   = DATA_S;
      end
      DATA_S: if (mem_o.wready) begin
        rd_ptr_d = rd_ptr_q + CNT_W'(1);
        if (wlast) begin
          wvalid_d = 1'b0;
          state_d  = RESP_S;
        end
      end
      RESP_S: if (mem_o.bvalid) begin
        if (mem_o.bresp != 2'b00) err_flag_d = 1'b1;
        cur_addr_d = cur_addr_q + (ADDR_WIDTH'(buf_cnt_q) << OFF_W);
        if (last_seen_q) begin
          done_d     = 1'b1;
          pkt_size_d = byte_cnt_q;
          trunc_d    = 1'b0;
          wr_err_d   = err_flag_d;
          state_d    = IDLE_S;
        // Less than one full word of room left counts as full.
        end else if ({1'b0, byte_cnt_q} + (SIZE_W+1)'(DATA_WIDTH_B) > (SIZE_W+1)'(MAX_PKT_SIZE_B)) begin
          state_d = DROP_S;
        end else begin
          state_d = FILL_S;
        end
      end
      DROP_S: if (pkt_i.tvalid && pkt_i.tlast) begin
        done_d     = 1'b1;
        pkt_size_d = byte_cnt_q;
        trunc_d    = 1'b1;
        wr_err_d   = err_flag_q;
        state_d    = IDLE_S;
      end
      default: state_d = IDLE_S;
    endcase
    if (state_d == FILL_S && state_q != FILL_S) begin
      buf_cnt_d   = '0;
      burst_lim_d = calc_lim(cur_addr_d, byte_cnt_d);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE_S;
      cur_addr_q  <= '0;
      awaddr_q    <= '0;
      byte_cnt_q  <= '0;
      pkt_size_q  <= '0;
      buf_cnt_q   <= '0;
      burst_lim_q <= '0;
      rd_ptr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      last_seen_q <= 1'b0;
      err_flag_q  <= 1'b0;
      done_q      <= 1'b0;
      trunc_q     <= 1'b0;
      wr_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      awaddr_q    <= awaddr_d;
      byte_cnt_q  <= byte_cnt_d;
      pkt_size_q  <= pkt_size_d;
      buf_cnt_q   <= buf_cnt_d;
      burst_lim_q <= burst_lim_d;
      rd_ptr_q    <= rd_ptr_d;
      awlen_q     <= awlen_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      last_seen_q <= last_seen_d;
      err_flag_q  <= err_flag_d;
      done_q      <= done_d;
      trunc_q     <= trunc_d;
      wr_err_q    <= wr_err_d;
    end
  end

  // NOTE: the burst buffer has no reset; it is always written before it is read.
  always_ff @(posedge clk_i) begin
    if (state_q == FILL_S && pkt_i.tvalid) begin
      buf_data_q[buf_cnt_q[IDX_W-1:0]] <= pkt_i.tdata;
      buf_keep_q[buf_cnt_q[IDX_W-1:0]] <= pkt_i.tkeep;
    end
  end

  assign pkt_i.tready   = (state_q == FILL_S) || (state_q == DROP_S);

  assign mem_o.awid     = '0;
  assign mem_o.awaddr   = awaddr_q;
  assign mem_o.awlen    = awlen_q;
  assign mem_o.awsize   = 3'(OFF_W);
  assign mem_o.awburst  = 2'b01;
  assign mem_o.awlock   = 1'b0;
  assign mem_o.awcache  = '0;
  assign mem_o.awprot   = '0;
  assign mem_o.awqos    = '0;
  assign mem_o.awregion = '0;
  assign mem_o.awuser   = '0;
  assign mem_o.awvalid  = awvalid_q;
  assign mem_o.wdata    = buf_data_q[rd_ptr_q[IDX_W-1:0]];
  assign mem_o.wstrb    = buf_keep_q[rd_ptr_q[IDX_W-1:0]];
  assign mem_o.wlast    = wlast;
  assign mem_o.wuser    = '0;
  assign mem_o.wvalid   = wvalid_q;
  assign mem_o.bready   = (state_q == RESP_S);
  assign mem_o.arid     = '0;
  assign mem_o.araddr   = '0;
  assign mem_o.arlen    = '0;
  assign mem_o.arsize   = '0;
  assign mem_o.arburst  = '0;
  assign mem_o.arlock   = 1'b0;
  assign mem_o.arcache  = '0;
  assign mem_o.arprot   = '0;
  assign mem_o.arqos    = '0;
  assign mem_o.arregion = '0;
  assign mem_o.aruser   = '0;
  assign mem_o.arvalid  = 1'b0;
  assign mem_o.rready   = 1'b1;

  assign pkt_size_o = pkt_size_q;
  assign done_o     = done_q;
  assign trunc_o    = trunc_q;
  assign wr_err_o   = wr_err_q;
endmodule

// File: tb/tb_axi4_stream_to_axi4.sv
// Directed bench for axi4_stream_to_axi4: a vector table of packets checked against
// a behavioural memory slave, plus a mid-transfer reset sequence.
module tb_axi4_stream_to_axi4;
  localparam int DW = 64, AW = 32, MAXB = 2048;

  typedef struct {
    logic [31:0] addr;
    int          nbytes;
    bit          zl;       // extra final word with tkeep = 0
    bit          stall;
    int          slverr;   // burst index answered with SLVERR, -1 for none
    bit          stb_mid;
    int          size;
    bit          trunc;
    bit          err;
    int          nb;
    logic [31:0] aw0;
    int          len0;
    logic [31:0] aw1;
    int          len1;
    logic [7:0]  lstrb;
  } vec_t;

  logic        clk = 1'b0, rst = 1'b1, wr_stb = 1'b0;
  logic [31:0] addr = '0;
  logic [11:0] pkt_size;
  logic        done, trunc, wr_err;

  axi4_stream_if #(.DATA_WIDTH(DW)) s_if ();
  axi4_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1), .AWUSER_WIDTH(1),
            .WUSER_WIDTH(1), .ARUSER_WIDTH(1)) m_if ();

  axi4_stream_to_axi4 dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wr_stb_i(wr_stb),
    .pkt_i(s_if), .mem_o(m_if),
    .pkt_size_o(pkt_size), .done_o(done), .trunc_o(trunc), .wr_err_o(wr_err)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pat(int k);
    return {32'hDA7A_0000 ^ 32'(k), 32'(k) * 32'h0100_0193};
  endfunction

  function automatic logic [7:0] keep_of(int k, int nbytes);
    int full = nbytes / 8, rem = nbytes % 8;
    if (k < full) return 8'hFF;
    if (k == full && rem != 0) return 8'((1 << rem) - 1);
    return 8'h00;
  endfunction

  // Memory slave model
  bit          stall = 0;
  int          slverr_burst = -1, resp_idx = 0, resp_pend = 0, beat = 0, wlast_bad = 0;
  logic [31:0] bur_addr[$];
  int          bur_len[$];
  logic [63:0] mem_d[logic [31:0]];
  logic [7:0]  mem_s[logic [31:0]];

  always begin
    logic        aw_hs, w_hs, b_hs, w_last;
    logic [31:0] a_addr, wa;
    logic [7:0]  a_len, w_strb;
    logic [63:0] w_data;
    @(negedge clk);
    aw_hs = m_if.awvalid && m_if.awready;  a_addr = m_if.awaddr; a_len = m_if.awlen;
    w_hs  = m_if.wvalid && m_if.wready;    w_data = m_if.wdata;  w_strb = m_if.wstrb;
    w_last = m_if.wlast;
    b_hs  = m_if.bvalid && m_if.bready;
    @(posedge clk);
    #1;
    if (rst) begin
      m_if.awready = 1'b0; m_if.wready = 1'b0; m_if.bvalid = 1'b0; m_if.bresp = 2'b00;
      beat = 0; resp_pend = 0;
    end else begin
      if (aw_hs) begin
        bur_addr.push_back(a_addr);
        bur_len.push_back(int'(a_len));
        beat = 0;
      end
      if (w_hs) begin
        if (bur_addr.size() == 0) wlast_bad++;
        else begin
          wa = bur_addr[$] + 32'(beat * 8);
          mem_d[wa] = w_data;
          mem_s[wa] = w_strb;
          if (w_last != (beat == bur_len[$])) wlast_bad++;
          beat++;
          if (w_last) resp_pend++;
        end
      end
      if (b_hs) m_if.bvalid = 1'b0;
      if (!m_if.bvalid && resp_pend > 0 && (!stall || $urandom_range(0, 2) == 0)) begin
        m_if.bvalid = 1'b1;
        m_if.bresp  = (resp_idx == slverr_burst) ? 2'b10 : 2'b00;
        resp_idx++;
        resp_pend--;
      end
      m_if.awready = !stall || ($urandom_range(0, 1) == 1);
      m_if.wready  = !stall || ($urandom_range(0, 1) == 1);
    end
  end

  task automatic send_pkt(input int nbytes, input bit zl, output bit to);
    int nw = (nbytes + 7) / 8 + int'(zl);
    bit hs;
    to = 1'b0;
    for (int k = 0; k < nw; k++) begin
      s_if.tdata = pat(k); s_if.tkeep = keep_of(k, nbytes);
      s_if.tlast = (k == nw - 1); s_if.tvalid = 1'b1;
      hs = 1'b0;
      for (int g = 0; g < 5000 && !hs; g++) begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk);
        #1;
      end
      if (!hs) begin
        to = 1'b1;
        break;
      end
    end
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
  endtask

  task automatic wait_done(input bit stb_mid, output bit got, output logic [11:0] sz,
                           output logic tr, output logic er);
    got = 1'b0; sz = '0; tr = 1'b0; er = 1'b0;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      if (stb_mid && c == 4) begin addr = 32'h9000; wr_stb = 1'b1; end
      if (c == 5) wr_stb = 1'b0;
      if (done) begin
        got = 1'b1; sz = pkt_size; tr = trunc; er = wr_err;
        break;
      end
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    bit          to, got;
    logic [11:0] sz;
    logic        tr, er;
    int          nwr, derr;
    logic [31:0] base, wa;
    bur_addr.delete(); bur_len.delete(); mem_d.delete(); mem_s.delete();
    wlast_bad = 0; resp_idx = 0; stall = v.stall; slverr_burst = v.slverr;
    @(posedge clk);
    #1;
    addr = v.addr; wr_stb = 1'b1;
    @(posedge clk);
    #1;
    wr_stb = 1'b0;
    fork
      send_pkt(v.nbytes, v.zl, to);
      wait_done(v.stb_mid, got, sz, tr, er);
    join
    check({tag, ".drv_timeout"}, to, 0);
    check({tag, ".done_seen"}, got, 1);
    check({tag, ".pkt_size"}, sz, v.size);
    check({tag, ".trunc"}, tr, v.trunc);
    check({tag, ".wr_err"}, er, v.err);
    @(negedge clk);
    check({tag, ".done_pulse"}, done, 0);
    check({tag, ".size_hold"}, pkt_size, v.size);
    check({tag, ".nbursts"}, bur_addr.size(), v.nb);
    if (bur_addr.size() > 0) begin
      check({tag, ".aw0"}, bur_addr[0], v.aw0);
      check({tag, ".len0"}, bur_len[0], v.len0);
    end
    if (v.nb > 1 && bur_addr.size() > 1) begin
      check({tag, ".aw1"}, bur_addr[1], v.aw1);
      check({tag, ".len1"}, bur_len[1], v.len1);
    end
    check({tag, ".wlast"}, wlast_bad, 0);
    nwr  = v.trunc ? MAXB / 8 : (v.nbytes + 7) / 8 + int'(v.zl);
    base = v.addr & ~32'h7;
    derr = 0;
    for (int k = 0; k < nwr; k++) begin
      wa = base + 32'(k * 8);
      if (!mem_d.exists(wa)) derr++;
      else if (mem_d[wa] !== pat(k) || mem_s[wa] !== keep_of(k, v.nbytes)) derr++;
    end
    check({tag, ".data"}, derr, 0);
    check({tag, ".word_count"}, mem_d.num(), nwr);
    wa = base + 32'((nwr - 1) * 8);
    check({tag, ".last_strb"}, mem_s.exists(wa) ? mem_s[wa] : 8'hXX, v.lstrb);
  endtask

  vec_t vecs[9];

  initial begin
    bit   to, seen;
    int   wcnt;
    vec_t post;
    //          addr          nbytes zl st err mid size trunc err nb aw0           len0 aw1           len1 lstrb
    vecs[0] = '{32'h0000_1000,   40, 0, 0, -1, 0,   40, 0, 0, 1, 32'h0000_1000,   4, 32'h0,           0, 8'hFF};
    vecs[1] = '{32'h0000_0000, 2048, 0, 0, -1, 0, 2048, 0, 0, 1, 32'h0000_0000, 255, 32'h0,           0, 8'hFF};
    vecs[2] = '{32'h0000_0FF0,   37, 0, 0, -1, 0,   37, 0, 0, 2, 32'h0000_0FF0,   1, 32'h0000_1000, 2, 8'h1F};
    vecs[3] = '{32'h0000_2000, 2100, 0, 0, -1, 0, 2048, 1, 0, 1, 32'h0000_2000, 255, 32'h0,           0, 8'hFF};
    vecs[4] = '{32'h0000_3008,   16, 1, 0, -1, 0,   16, 0, 0, 1, 32'h0000_3008,   2, 32'h0,           0, 8'h00};
    vecs[5] = '{32'h0000_0FC0,   64, 0, 0, -1, 0,   64, 0, 0, 1, 32'h0000_0FC0,   7, 32'h0,           0, 8'hFF};
    vecs[6] = '{32'h0000_5005,    8, 0, 0, -1, 0,    8, 0, 0, 1, 32'h0000_5000,   0, 32'h0,           0, 8'hFF};
    vecs[7] = '{32'h0000_0FF0,   37, 0, 1,  0, 1,   37, 0, 1, 2, 32'h0000_0FF0,   1, 32'h0000_1000, 2, 8'h1F};
    vecs[8] = '{32'h0000_7F00,  300, 0, 1, -1, 0,  300, 0, 0, 2, 32'h0000_7F00,  31, 32'h0000_8000, 5, 8'h0F};
    post    = '{32'h0000_6000,   40, 0, 0, -1, 0,   40, 0, 0, 1, 32'h0000_6000,   4, 32'h0,           0, 8'hFF};

    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.tdata = '0; s_if.tkeep = '0;
    m_if.bid = '0; m_if.arready = 1'b0; m_if.rid = '0; m_if.rdata = '0;
    m_if.rresp = '0; m_if.rlast = 1'b0; m_if.rvalid = 1'b0;

    #12;
    check("rst.awvalid", m_if.awvalid, 0);
    check("rst.wvalid", m_if.wvalid, 0);
    check("rst.tready", s_if.tready, 0);
    check("rst.done", done, 0);
    check("rst.pkt_size", pkt_size, 0);
    check("rst.awaddr", m_if.awaddr, 0);
    check("rst.awlen", m_if.awlen, 0);
    check("rst.arvalid", m_if.arvalid, 0);
    check("rst.rready", m_if.rready, 1);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while the write data channel is active
    bur_addr.delete(); bur_len.delete(); mem_d.delete(); mem_s.delete();
    stall = 0; slverr_burst = -1; resp_idx = 0;
    @(posedge clk);
    #1;
    addr = 32'h4000; wr_stb = 1'b1;
    @(posedge clk);
    #1;
    wr_stb = 1'b0;
    seen = 1'b0; wcnt = 0;
    fork
      send_pkt(100, 1'b0, to);
      begin
        for (int c = 0; c < 3000 && !seen; c++) begin
          @(negedge clk);
          if (m_if.wvalid) wcnt++;
          if (wcnt == 3) seen = 1'b1;
        end
      end
    join
    check("mid.reach_data", seen, 1);
    #2;
    rst = 1'b1;
    #1;
    check("mid.awvalid", m_if.awvalid, 0);
    check("mid.wvalid", m_if.wvalid, 0);
    check("mid.tready", s_if.tready, 0);
    check("mid.pkt_size", pkt_size, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_vec("post_rst", post);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
